// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: one output register plus a one-entry skid
// buffer, valid/ready on both sides, saturating illegal-mode counter.
module imm_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [2:0] {
        MODE_ZERO       = 3'd0,
        MODE_SIGNED     = 3'd1,
        MODE_HIGHPOS    = 3'd2,
        MODE_SIGNED_SL2 = 3'd3,
        MODE_ZERO_SL2   = 3'd4
    } mode_e;

    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_err;

    logic              accept;
    logic              out_free;

    assign accept   = in_valid && in_ready;
    // Output register may be (re)loaded when empty or being consumed this cycle
    assign out_free = !out_valid || out_ready;
    // Skid occupancy is a flop, so in_ready is registered by construction
    assign in_ready = !skid_valid;

    // Combinational extension of the incoming immediate according to its mode
    always_comb begin
        zext     = {{(DATA_W-IMM_W){1'b0}}, in_imm};
        sext     = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            MODE_ZERO:       ext_data = zext;
            MODE_SIGNED:     ext_data = sext;
            MODE_HIGHPOS:    ext_data = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_SIGNED_SL2: ext_data = {sext[DATA_W-3:0], 2'b00};
            MODE_ZERO_SL2:   ext_data = {zext[DATA_W-3:0], 2'b00};
            default: begin
                ext_data = '0;
                ext_err  = 1'b1;
            end
        endcase
    end

    // Output register and skid entry: two-deep FIFO ordering, skid drains first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_tag    <= skid_tag;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= ext_data;
                out_tag   <= in_tag;
                out_err   <= ext_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= ext_data;
            skid_tag   <= in_tag;
            skid_err   <= ext_err;
        end
    end

    // Count accepted illegal-mode requests, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && ext_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Default-parameter DUT
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_data;
    logic [7:0]  err_cnt;

    // Narrow-counter DUT (CNT_W=2)
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
    logic [15:0] s_in_imm;
    logic [2:0]  s_in_mode;
    logic [4:0]  s_in_tag, s_out_tag;
    logic [31:0] s_out_data;
    logic [1:0]  s_err_cnt;

    // Narrow-datapath DUT (IMM_W=8, DATA_W=16)
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_err;
    logic [7:0]  n_in_imm;
    logic [2:0]  n_in_mode;
    logic [4:0]  n_in_tag, n_out_tag;
    logic [15:0] n_out_data;
    logic [7:0]  n_err_cnt;

    imm_ext_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt)
    );

    imm_ext_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm),
        .in_mode(s_in_mode), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_tag(s_out_tag), .out_err(s_out_err), .err_cnt(s_err_cnt)
    );

    imm_ext_pipe #(.IMM_W(8), .DATA_W(16)) dut_nar (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_imm(n_in_imm),
        .in_mode(n_in_mode), .in_tag(n_in_tag),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_tag(n_out_tag), .out_err(n_out_err), .err_cnt(n_err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } item_t;

    // Reference model: ordered list of results held by the block (capacity 2)
    item_t q[$];
    int    model_cnt = 0;

    // Extension rules in plain integer arithmetic (16-bit imm, 32-bit result)
    function automatic item_t ref_item(logic [15:0] imm, logic [2:0] mode, logic [4:0] tag);
        longint z, s, v;
        item_t  it;
        z = longint'(imm);
        s = imm[15] ? z - 65536 : z;
        it.tag = tag;
        it.err = 1'b0;
        case (mode)
            3'd0: v = z;
            3'd1: v = s;
            3'd2: v = z * 65536;
            3'd3: v = s * 4;
            3'd4: v = z * 4;
            default: begin
                v = 0;
                it.err = 1'b1;
            end
        endcase
        it.data = v[31:0];
        return it;
    endfunction

    // Apply one cycle of stimulus to the main DUT and advance the model
    task automatic drive_cycle(input bit v, input logic [15:0] imm, input logic [2:0] mode,
                               input logic [4:0] tag, input bit rdy);
        bit acc, drn;
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = rdy;
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (drn) void'(q.pop_front());
        if (acc) begin
            q.push_back(ref_item(imm, mode, tag));
            if (mode > 3'd4 && model_cnt < 255) model_cnt++;
        end
    endtask

    task automatic test_reset();
        in_valid = 0; out_ready = 0;
        rst = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
            out_tag !== 5'h0 || out_err !== 1'b0 || err_cnt !== 8'h0) begin
            failures++;
            $display("FAIL reset: valid=%b ready=%b data=%h tag=%h err=%b cnt=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, out_data, out_tag, out_err, err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        model_cnt = 0;
    endtask

    task automatic test_mode_sweep();
        logic [31:0] exp_tab [5];
        exp_tab = '{32'h0000_8004, 32'hFFFF_8004, 32'h8004_0000, 32'hFFFE_0010, 32'h0002_0010};
        for (int m = 0; m < 5; m++) begin
            drive_cycle(1, 16'h8004, 3'(m), 5'(m), 1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[m] || out_tag !== 5'(m) || out_err !== 1'b0) begin
                failures++;
                $display("FAIL mode_sweep m=%0d: valid=%b data=%h tag=%h err=%b, required 1 %h %h 0",
                         m, out_valid, out_data, out_tag, out_err, exp_tab[m], 5'(m));
            end
        end
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mode_sweep_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1, 16'($urandom), 3'($urandom_range(0, 4)), 5'(i), 1);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 5'(i) ||
                item_t'({out_data, out_tag, out_err}) !== q[0]) begin
                failures++;
                $display("FAIL back_to_back i=%0d: ready=%b valid=%b data=%h tag=%h err=%b, required 1 1 %h %h %b",
                         i, in_ready, out_valid, out_data, out_tag, out_err, q[0].data, q[0].tag, q[0].err);
            end
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_tag [5];
        logic       exp_rdy [5];
        bit         rdy_tab [5];
        exp_tag = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd3};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rdy_tab = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            // third request (tag 3) is held valid from cycle 2 until accepted
            drive_cycle(1, 16'h1000 + 16'(i), 3'd0, (i < 2) ? 5'(i + 1) : 5'd3, rdy_tab[i]);
            checks++;
            if (in_ready !== exp_rdy[i] || out_valid !== 1'b1 || out_tag !== exp_tag[i] ||
                item_t'({out_data, out_tag, out_err}) !== q[0]) begin
                failures++;
                $display("FAIL backpressure step=%0d: ready=%b valid=%b tag=%h data=%h, required %b 1 %h %h",
                         i, in_ready, out_valid, out_tag, out_data, exp_rdy[i], exp_tag[i], q[0].data);
            end
        end
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_end: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 16'hBEEF, 3'(5 + i), 5'(i), 1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b1 || err_cnt !== 8'(i + 1)) begin
                failures++;
                $display("FAIL illegal m=%0d: valid=%b data=%h err=%b cnt=%0d, required 1 0 1 %0d",
                         5 + i, out_valid, out_data, out_err, err_cnt, i + 1);
            end
        end
        // stall: one more illegal accepted, then a held-off illegal must not count
        drive_cycle(1, 16'h0001, 3'd5, 5'd9, 0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 16'h0002, 3'd6, 5'd10, 0);
            checks++;
            if (err_cnt !== 8'd4 || in_ready !== 1'b0 || out_err !== 1'b1) begin
                failures++;
                $display("FAIL illegal_stall: cnt=%0d ready=%b err=%b, required 4 0 1", err_cnt, in_ready, out_err);
            end
        end
        drive_cycle(0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_saturate();
        s_in_valid  = 1'b1;
        s_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in_mode = 3'(5 + (i % 3));
            @(posedge clk);
            #1;
            checks++;
            if (s_err_cnt !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1)) || s_out_err !== 1'b1) begin
                failures++;
                $display("FAIL saturate n=%0d: cnt=%0d err=%b, required %0d 1",
                         i + 1, s_err_cnt, s_out_err, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 16'h4321, 3'd7, 5'd1, 0);
        drive_cycle(1, 16'h5555, 3'd1, 5'd2, 0);
        checks++;
        if (in_ready !== 1'b0 || err_cnt !== 8'(model_cnt) || model_cnt == 0) begin
            failures++;
            $display("FAIL reset_mid_fill: ready=%b cnt=%0d, required 0 %0d", in_ready, err_cnt, model_cnt);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'h0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_async: valid=%b ready=%b cnt=%0d data=%h, required 0 1 0 0",
                     out_valid, in_ready, err_cnt, out_data);
        end
        q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle(1, 16'h1234, 3'd1, 5'd9, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_1234 || out_tag !== 5'd9 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_post: valid=%b data=%h tag=%h err=%b, required 1 00001234 09 0",
                     out_valid, out_data, out_tag, out_err);
        end
        drive_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_param_corner();
        logic [15:0] exp_tab [5];
        exp_tab = '{16'h0081, 16'hFF81, 16'h8100, 16'hFE04, 16'h0204};
        n_out_ready = 1'b1;
        n_in_valid  = 1'b1;
        n_in_imm    = 8'h81;
        for (int m = 0; m < 5; m++) begin
            n_in_mode = 3'(m);
            n_in_tag  = 5'(m);
            @(posedge clk);
            #1;
            checks++;
            if (n_out_valid !== 1'b1 || n_out_data !== exp_tab[m] || n_out_tag !== 5'(m)) begin
                failures++;
                $display("FAIL param_corner m=%0d: valid=%b data=%h tag=%h, required 1 %h %h",
                         m, n_out_valid, n_out_data, n_out_tag, exp_tab[m], 5'(m));
            end
        end
        n_in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || err_cnt !== 8'(model_cnt) ||
                (q.size() > 0 && item_t'({out_data, out_tag, out_err}) !== q[0])) begin
                failures++;
                $display("FAIL random cyc=%0d: valid=%b ready=%b cnt=%0d data=%h tag=%h err=%b, required depth=%0d cnt=%0d front=%h",
                         i, out_valid, in_ready, err_cnt, out_data, out_tag, out_err,
                         q.size(), model_cnt, (q.size() > 0) ? q[0] : item_t'('0));
            end
            drive_cycle($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom_range(0, 7)),
                        5'($urandom), $urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_imm = 0; in_mode = 0; in_tag = 0; out_ready = 0;
        s_in_valid = 0; s_in_imm = 0; s_in_mode = 0; s_in_tag = 0; s_out_ready = 0;
        n_in_valid = 0; n_in_imm = 0; n_in_mode = 0; n_in_tag = 0; n_out_ready = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_mode_sweep();
        test_back_to_back();
        test_backpressure();
        test_reset();
        test_illegal();
        test_saturate();
        test_reset_mid();
        test_param_corner();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
